// File: rtl/pipe_rca_pkg.sv
// Shared helpers for the segmented pipelined ripple-carry adder.
package pipe_rca_pkg;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && (width % seg_w == 0);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG_W-bit ripple-carry segment.
// c_msb (carry into the top bit) exists only with PIPE_RCA_OVF_EN.
module rca_seg #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
`ifdef PIPE_RCA_OVF_EN
    output logic         c_msb,
`endif
    output logic         co
);

    always_comb begin
        logic c;
        c = ci;
        s = '0;
`ifdef PIPE_RCA_OVF_EN
        c_msb = 1'b0;
`endif
        for (int i = 0; i < W; i++) begin
`ifdef PIPE_RCA_OVF_EN
            if (i == W - 1) c_msb = c;
`endif
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/pipe_rca.sv
// Pipelined segmented add/sub with valid/ready backpressure.
// Define PIPE_RCA_OVF_EN to add the signed-overflow output ovf.
module pipe_rca
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int SEG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
`ifdef PIPE_RCA_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
        $error("pipe_rca: WIDTH must be a nonzero multiple of SEG_W");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
`ifdef PIPE_RCA_OVF_EN
        logic             ovf;
`endif
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t           pl_q   [NSEG];
    stage_t           pl_d   [NSEG];
    logic [NSEG-1:0]  adv;
    logic [WIDTH-1:0] op_a   [NSEG];
    logic [WIDTH-1:0] op_b   [NSEG];
    logic [WIDTH-1:0] res_in [NSEG];
    logic [NSEG-1:0]  ci;
    logic [NSEG-1:0]  vin;
    logic [SEG_W-1:0] sum    [NSEG];
    logic [NSEG-1:0]  co;
`ifdef PIPE_RCA_OVF_EN
    logic [NSEG-1:0]  cm;
`endif

    // Advance chain runs back from the output so bubbles collapse.
    always_comb begin
        logic nxt;
        nxt = out_ready | ~pl_q[NSEG-1].valid;
        adv = '0;
        adv[NSEG-1] = nxt;
        for (int k = NSEG - 2; k >= 0; k--) begin
            nxt    = ~pl_q[k].valid | nxt;
            adv[k] = nxt;
        end
    end

    always_comb begin
        op_a[0]   = a;
        op_b[0]   = sub ? ~b : b;
        ci[0]     = sub ^ cin;
        vin[0]    = in_valid;
        res_in[0] = '0;
        for (int k = 1; k < NSEG; k++) begin
            op_a[k]   = pl_q[k-1].a;
            op_b[k]   = pl_q[k-1].b;
            ci[k]     = pl_q[k-1].carry;
            vin[k]    = pl_q[k-1].valid;
            res_in[k] = pl_q[k-1].res;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        rca_seg #(.W(SEG_W)) u_seg (
            .a     (op_a[k][k*SEG_W +: SEG_W]),
            .b     (op_b[k][k*SEG_W +: SEG_W]),
            .ci    (ci[k]),
            .s     (sum[k]),
`ifdef PIPE_RCA_OVF_EN
            .c_msb (cm[k]),
`endif
            .co    (co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            pl_d[k] = pl_q[k];
            if (adv[k]) begin
                pl_d[k].valid = vin[k];
                pl_d[k].carry = co[k];
                pl_d[k].res   = res_in[k];
                pl_d[k].res[k*SEG_W +: SEG_W] = sum[k];
                pl_d[k].a     = op_a[k];
                pl_d[k].b     = op_b[k];
`ifdef PIPE_RCA_OVF_EN
                pl_d[k].ovf   = cm[k] ^ co[k];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) pl_q[k] <= '0;
        end else begin
            for (int k = 0; k < NSEG; k++) pl_q[k] <= pl_d[k];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = pl_q[NSEG-1].valid;
    assign r         = pl_q[NSEG-1].res;
    assign cout      = pl_q[NSEG-1].carry;
`ifdef PIPE_RCA_OVF_EN
    assign ovf       = pl_q[NSEG-1].ovf;
`endif

endmodule

// File: tb/tb_pipe_rca.sv
// Bench for pipe_rca (WIDTH=12, SEG_W=6): vector table, random stream,
// backpressure and mid-flight reset, with a queue scoreboard.
module tb_pipe_rca;

    typedef struct {
        logic [11:0] r;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        cin;
        logic        sub;
        logic [11:0] r;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] a = '0;
    logic [11:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] r;
    logic        cout;
`ifdef PIPE_RCA_OVF_EN
    logic        ovf;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   ir_drop = 0;
    exp_t cur_exp;
    exp_t sb[$];
    vec_t tbl[10];

    pipe_rca #(.WIDTH(12), .SEG_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
`ifdef PIPE_RCA_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [11:0] x, input logic [11:0] y,
                                   input logic c, input logic s);
        exp_t        e;
        logic [11:0] be;
        logic        ce;
        logic [12:0] t;
        logic [11:0] lo;
        be = s ? ~y : y;
        ce = s ? ~c : c;
        t  = {1'b0, x} + {1'b0, be} + {12'd0, ce};
        lo = {1'b0, x[10:0]} + {1'b0, be[10:0]} + {11'd0, ce};
        e.r    = t[11:0];
        e.cout = t[12];
        e.ovf  = lo[11] ^ t[12];
        return e;
    endfunction

    // Scoreboard: sampled on the falling edge, transfers land on the next rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", {19'd0, cout, r}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", {19'd0, cout, r}, {19'd0, e.cout, e.r});
`ifdef PIPE_RCA_OVF_EN
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(cur_exp);
                n_in++;
            end
        end
    end

    task automatic send(input logic [11:0] x, input logic [11:0] y,
                        input logic c, input logic s, input exp_t e);
        logic ok;
        ok = 1'b0;
        #1;
        in_valid = 1'b1;
        a = x; b = y; cin = c; sub = s;
        cur_exp = e;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) ir_drop++;
            @(posedge clk);
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        exp_t        e;
        logic [11:0] hold_r;
        int          n0;

        tbl[0] = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0};
        tbl[1] = '{12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0};
        tbl[2] = '{12'h007, 12'h005, 1'b0, 1'b1, 12'h002, 1'b1, 1'b0};
        tbl[3] = '{12'h123, 12'h456, 1'b1, 1'b0, 12'h57A, 1'b0, 1'b0};
        tbl[4] = '{12'h000, 12'h000, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0};
        tbl[5] = '{12'h000, 12'h000, 1'b1, 1'b1, 12'hFFF, 1'b0, 1'b0};
        tbl[6] = '{12'h03F, 12'h001, 1'b0, 1'b0, 12'h040, 1'b0, 1'b0};
        tbl[7] = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0};
        tbl[8] = '{12'h800, 12'h001, 1'b0, 1'b1, 12'h7FF, 1'b1, 1'b1};
        tbl[9] = '{12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_r", {20'd0, r}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Latency: accepted at edge N, valid after edge N+1.
        @(posedge clk);
        e = '{12'h000, 1'b1, 1'b0};
        send(12'hFFF, 12'h001, 1'b0, 1'b0, e);
        #1;
        in_valid = 1'b0;
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_r", {19'd0, cout, r}, {19'd0, 1'b1, 12'h000});
        @(posedge clk);
        drain("drain_lat");

        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            e = '{tbl[i].r, tbl[i].cout, tbl[i].ovf};
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, e);
        end
        #1;
        in_valid = 1'b0;
        drain("drain_tbl");

        @(posedge clk);
        ir_drop = 0;
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            logic [11:0] x, y;
            logic        c, s;
            x = 12'($urandom);
            y = 12'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            send(x, y, c, s, model(x, y, c, s));
        end
        #1;
        in_valid = 1'b0;
        drain("drain_rand");
        chk("rand_in_ready_drops", ir_drop, 0);
        chk("rand_count", n_out - n0, 100);

        // Backpressure: stall output, expect exactly two accepted.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n0 = n_in;
        @(posedge clk);
        send(12'h111, 12'h222, 1'b0, 1'b0, model(12'h111, 12'h222, 1'b0, 1'b0));
        send(12'h0AB, 12'h00C, 1'b1, 1'b1, model(12'h0AB, 12'h00C, 1'b1, 1'b1));
        #1;
        a = 12'h300; b = 12'h0F0; cin = 1'b0; sub = 1'b0;
        cur_exp = model(12'h300, 12'h0F0, 1'b0, 1'b0);
        hold_r = r;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_r_stable", {20'd0, r}, {20'd0, hold_r});
        end
        chk("bp_accepted", n_in - n0, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("drain_bp");
        chk("bp_total", n_in - n0, 3);

        // Reset with two items held in flight.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        send(12'h555, 12'h0AA, 1'b0, 1'b0, model(12'h555, 12'h0AA, 1'b0, 1'b0));
        send(12'h321, 12'h123, 1'b0, 1'b1, model(12'h321, 12'h123, 1'b0, 1'b1));
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_r", {20'd0, r}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_no_output", n_out - n0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
